// File: rtl/stopwatch_ctrl_pkg.sv
// Shared definitions for the four-digit BCD stopwatch controller:
// FSM state encodings, BCD limits and the mod-10 increment helper.
package stopwatch_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_LAP  = 2'b10,
        S_STOP = 2'b11
    } state_t;

    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic [3:0] BCD_ZERO = 4'd0;

    // Any value at or above 9 rolls to 0, so a digit can never escape 0..9.
    function automatic logic [3:0] bcd_inc(input logic [3:0] d);
        return (d >= BCD_MAX) ? BCD_ZERO : d + 4'd1;
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_bcd_digit.sv
// One decimal counter digit with synchronous clear and a ripple enable-out
// so a chain of these forms a multi-digit BCD up-counter.
module bcd_digit
    import stopwatch_ctrl_pkg::*;
(
    input  logic       clock,
    input  logic       reset_,
    input  logic       clr,
    input  logic       ei,
    output logic [3:0] q3_q0,
    output logic       eu
);

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            q3_q0 <= BCD_ZERO;
        end else if (clr) begin
            q3_q0 <= BCD_ZERO;
        end else if (ei) begin
            q3_q0 <= bcd_inc(q3_q0);
        end
    end

    // Combinational carry so the whole chain rolls over on a single edge.
    assign eu = ei & (q3_q0 == BCD_MAX);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: start/stop/lap/clear FSM, count prescaler, four-digit
// BCD chain, lap register and the display mux feeding the 7-segment path.
module stopwatch_ctrl
    import stopwatch_ctrl_pkg::*;
#(
    parameter int PRESCALE = 10
) (
    input  logic        clock,
    input  logic        reset_,
    input  logic        ss,
    input  logic        lr,
    output logic [15:0] disp,
    output logic        running,
    output logic        lap_on,
    output logic        ovf
);

    // state  | meaning
    // IDLE   | cleared, waiting for start
    // RUN    | counting, display shows live count
    // LAP    | counting, display frozen on lap register
    // STOP   | count held, start resumes, lap/clear returns to IDLE

    localparam int PW = $clog2(PRESCALE);
    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

    state_t state;
    state_t state_nxt;
    logic   lap_load;
    logic   clr_all;
    logic   presc_clr;

    logic [PW-1:0] presc;
    logic          tick;
    logic [4:0]    en;
    logic [15:0]   count;
    logic [15:0]   lap_reg;

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ss is checked first in every state so a simultaneous lr is dropped.
    always_comb begin
        state_nxt = state;
        lap_load  = 1'b0;
        clr_all   = 1'b0;
        presc_clr = 1'b0;
        case (state)
            S_IDLE: begin
                if (ss) begin
                    state_nxt = S_RUN;
                    presc_clr = 1'b1;
                end
            end
            S_RUN: begin
                if (ss) begin
                    state_nxt = S_STOP;
                end else if (lr) begin
                    state_nxt = S_LAP;
                    lap_load  = 1'b1;
                end
            end
            S_LAP: begin
                if (ss) begin
                    state_nxt = S_STOP;
                end else if (lr) begin
                    state_nxt = S_RUN;
                end
            end
            S_STOP: begin
                if (ss) begin
                    state_nxt = S_RUN;
                    presc_clr = 1'b1;
                end else if (lr) begin
                    state_nxt = S_IDLE;
                    clr_all   = 1'b1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign running = (state == S_RUN) || (state == S_LAP);
    assign lap_on  = (state == S_LAP);

    // Prescaler keeps its phase across RUN<->LAP; only a fresh start clears it.
    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            presc <= '0;
        end else if (presc_clr) begin
            presc <= '0;
        end else if (running) begin
            if (presc == PRESC_MAX) begin
                presc <= '0;
            end else begin
                presc <= presc + PW'(1);
            end
        end
    end

    assign tick  = running && (presc == PRESC_MAX);
    assign en[0] = tick;

    for (genvar k = 0; k < 4; k++) begin : g_digit
        bcd_digit u_digit (
            .clock  (clock),
            .reset_ (reset_),
            .clr    (clr_all),
            .ei     (en[k]),
            .q3_q0  (count[4*k +: 4]),
            .eu     (en[k+1])
        );
    end

    // en[4] is the carry out of digit 3: the 9999 -> 0000 edge.
    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            ovf <= 1'b0;
        end else if (clr_all) begin
            ovf <= 1'b0;
        end else if (en[4]) begin
            ovf <= 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            lap_reg <= 16'h0000;
        end else if (clr_all) begin
            lap_reg <= 16'h0000;
        end else if (lap_load) begin
            lap_reg <= count;
        end
    end

    assign disp = lap_on ? lap_reg : count;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with PRESCALE=4: expected outputs are
// queued per step and compared against the DUT between clock edges.
`timescale 1ns/1ps
module tb_stopwatch_ctrl;

    logic        clock;
    logic        reset_;
    logic        ss;
    logic        lr;
    logic [15:0] disp;
    logic        running;
    logic        lap_on;
    logic        ovf;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [15:0] disp;
        logic        running;
        logic        lap_on;
        logic        ovf;
    } exp_t;

    exp_t sb[$];

    stopwatch_ctrl #(.PRESCALE(4)) dut (
        .clock   (clock),
        .reset_  (reset_),
        .ss      (ss),
        .lr      (lr),
        .disp    (disp),
        .running (running),
        .lap_on  (lap_on),
        .ovf     (ovf)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic expect_out(input string tag, input logic [15:0] d,
                              input logic r, input logic l, input logic o);
        exp_t e;
        e.tag = tag; e.disp = d; e.running = r; e.lap_on = l; e.ovf = o;
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        e = sb.pop_front();
        checks++;
        assert (disp === e.disp) else begin
            errors++;
            $error("FAIL %s disp observed=%h expected=%h", e.tag, disp, e.disp);
        end
        checks++;
        assert (running === e.running) else begin
            errors++;
            $error("FAIL %s running observed=%b expected=%b", e.tag, running, e.running);
        end
        checks++;
        assert (lap_on === e.lap_on) else begin
            errors++;
            $error("FAIL %s lap_on observed=%b expected=%b", e.tag, lap_on, e.lap_on);
        end
        checks++;
        assert (ovf === e.ovf) else begin
            errors++;
            $error("FAIL %s ovf observed=%b expected=%b", e.tag, ovf, e.ovf);
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] d,
                       input logic r, input logic l, input logic o);
        expect_out(tag, d, r, l, o);
        check_out();
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic pulse(input logic s, input logic l);
        ss = s;
        lr = l;
        @(negedge clock);
        ss = 1'b0;
        lr = 1'b0;
    endtask

    // Digit range monitor: every nibble of the display must stay in 0..9.
    always @(negedge clock) begin
        if (reset_ === 1'b1) begin
            for (int k = 0; k < 4; k++) begin
                logic [3:0] nib;
                nib = disp[4*k +: 4];
                checks++;
                assert (nib <= 4'd9) else begin
                    errors++;
                    $error("FAIL digit_range digit%0d observed=%h expected<=9", k, nib);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_ = 1'b0;
        ss     = 1'b0;
        lr     = 1'b0;
        #2;
        chk("reset_initial", 16'h0000, 1'b0, 1'b0, 1'b0);
        cycles(2);
        reset_ = 1'b1;
        cycles(20);
        chk("idle_after_reset", 16'h0000, 1'b0, 1'b0, 1'b0);

        // Basic count and start latency
        pulse(1'b1, 1'b0);
        chk("start_running", 16'h0000, 1'b1, 1'b0, 1'b0);
        cycles(3);
        chk("before_first_tick", 16'h0000, 1'b1, 1'b0, 1'b0);
        cycles(1);
        chk("first_tick", 16'h0001, 1'b1, 1'b0, 1'b0);
        cycles(36);
        chk("count_10", 16'h0010, 1'b1, 1'b0, 1'b0);
        pulse(1'b1, 1'b0);
        chk("stop_at_10", 16'h0010, 1'b0, 1'b0, 1'b0);
        cycles(20);
        chk("stop_hold", 16'h0010, 1'b0, 1'b0, 1'b0);

        // Lap hold
        pulse(1'b1, 1'b0);
        cycles(60);
        chk("run_to_25", 16'h0025, 1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b1);
        chk("lap_enter", 16'h0025, 1'b1, 1'b1, 1'b0);
        cycles(40);
        chk("lap_frozen", 16'h0025, 1'b1, 1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        chk("lap_exit_live", 16'h0035, 1'b1, 1'b0, 1'b0);

        // Clear
        cycles(26);
        chk("run_to_42", 16'h0042, 1'b1, 1'b0, 1'b0);
        pulse(1'b1, 1'b0);
        chk("stop_at_42", 16'h0042, 1'b0, 1'b0, 1'b0);
        pulse(1'b0, 1'b1);
        chk("clear_to_idle", 16'h0000, 1'b0, 1'b0, 1'b0);
        pulse(1'b0, 1'b1);
        cycles(8);
        chk("lr_in_idle", 16'h0000, 1'b0, 1'b0, 1'b0);

        // Simultaneous ss+lr in RUN: ss wins
        pulse(1'b1, 1'b0);
        cycles(8);
        chk("run_to_2", 16'h0002, 1'b1, 1'b0, 1'b0);
        pulse(1'b1, 1'b1);
        chk("ss_lr_same_cycle", 16'h0002, 1'b0, 1'b0, 1'b0);

        // ss coinciding with tick: increment still applied
        pulse(1'b1, 1'b0);
        cycles(3);
        pulse(1'b1, 1'b0);
        chk("ss_with_tick", 16'h0003, 1'b0, 1'b0, 1'b0);

        // lr coinciding with tick: lap gets pre-increment value
        pulse(1'b1, 1'b0);
        cycles(3);
        pulse(1'b0, 1'b1);
        chk("lr_with_tick_lap", 16'h0003, 1'b1, 1'b1, 1'b0);
        pulse(1'b1, 1'b0);
        chk("lap_to_stop_live", 16'h0004, 1'b0, 1'b0, 1'b0);
        pulse(1'b0, 1'b1);
        chk("clear_again", 16'h0000, 1'b0, 1'b0, 1'b0);

        // Carry chain and wrap
        pulse(1'b1, 1'b0);
        cycles(36);
        chk("carry_0009", 16'h0009, 1'b1, 1'b0, 1'b0);
        cycles(3);
        chk("carry_0009_hold", 16'h0009, 1'b1, 1'b0, 1'b0);
        cycles(1);
        chk("carry_0010", 16'h0010, 1'b1, 1'b0, 1'b0);
        cycles(356);
        chk("carry_0099", 16'h0099, 1'b1, 1'b0, 1'b0);
        cycles(3);
        chk("carry_0099_hold", 16'h0099, 1'b1, 1'b0, 1'b0);
        cycles(1);
        chk("carry_0100", 16'h0100, 1'b1, 1'b0, 1'b0);
        cycles(3596);
        chk("carry_0999", 16'h0999, 1'b1, 1'b0, 1'b0);
        cycles(3);
        chk("carry_0999_hold", 16'h0999, 1'b1, 1'b0, 1'b0);
        cycles(1);
        chk("carry_1000", 16'h1000, 1'b1, 1'b0, 1'b0);
        cycles(35992);
        chk("count_9998", 16'h9998, 1'b1, 1'b0, 1'b0);
        cycles(4);
        chk("count_9999", 16'h9999, 1'b1, 1'b0, 1'b0);
        cycles(4);
        chk("wrap_0000_ovf", 16'h0000, 1'b1, 1'b0, 1'b1);
        cycles(8);
        chk("wrap_continues", 16'h0002, 1'b1, 1'b0, 1'b1);
        pulse(1'b1, 1'b0);
        chk("ovf_sticky_stop", 16'h0002, 1'b0, 1'b0, 1'b1);
        pulse(1'b0, 1'b1);
        chk("ovf_cleared", 16'h0000, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset mid-run
        pulse(1'b1, 1'b0);
        cycles(10);
        chk("run_before_reset", 16'h0002, 1'b1, 1'b0, 1'b0);
        #2;
        reset_ = 1'b0;
        #1;
        chk("async_reset", 16'h0000, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        reset_ = 1'b1;
        cycles(20);
        chk("idle_after_midrun_reset", 16'h0000, 1'b0, 1'b0, 1'b0);
        pulse(1'b1, 1'b0);
        cycles(4);
        chk("restart_after_reset", 16'h0001, 1'b1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Four-digit BCD stopwatch controller. Sequences a cascade of four decimal up-counter digits with start/stop, lap-freeze and clear control, and generates the count enable from an internal clock prescaler. Sits between the front-panel pulse inputs and the 7-segment display path. It owns the digit registers and the lap register; the display path only reads `disp`.

## Interface
- `PRESCALE`, default 10: clock cycles per count increment; legal values are 2..1023.
- `clock`  in  1: single system clock; all state changes on the rising edge.
- `reset_`  in  1: asynchronous, active-low reset.
- `ss`  in  1: start/stop request, a one-cycle pulse sampled on the rising edge.
- `lr`  in  1: lap/clear request, a one-cycle pulse sampled on the rising edge.
- `disp`  out  16: four BCD digits, `disp[15:12]` most significant.
- `running`  out  1: 1 in states RUN and LAP.
- `lap_on`  out  1: 1 in state LAP.
- `ovf`  out  1: sticky flag, set when the count wraps from 9999 to 0000.

## Operation
- The FSM has four states: IDLE, RUN, LAP, STOP. Encoding is 2 bits, IDLE=00.
- IDLE:
  - `ss` → RUN.
  - `lr` is ignored.
  - The count is 0000.
- RUN:
  - `ss` → STOP.
  - `lr` → LAP, and the current count is copied into the lap register on the same edge.
- LAP:
  - Counting continues.
  - `lr` → RUN, and `disp` returns to the live count.
  - `ss` → STOP, and `disp` returns to the live count.
- STOP:
  - `ss` → RUN, resuming from the held count.
  - `lr` → IDLE, clearing the count, the lap register and `ovf`.
- If `ss` and `lr` arrive in the same cycle, `ss` wins and `lr` is dropped.
- Prescaler:
  - It is a `ceil(log2(PRESCALE))`-bit counter that advances only in RUN and LAP.
  - `tick`=1 when it reaches `PRESCALE-1`; it then wraps to 0.
  - It is cleared on every transition into RUN from IDLE or STOP.
  - It holds its value in LAP↔RUN transitions.
- Digit chain:
  - Digit 0 has enable `tick`.
  - The enable of digit k+1 is digit k's enable AND (digit k == 9).
  - An enabled digit at 9 goes to 0; otherwise it increments.
  - Digits never hold values 10..15.
- Wrap: on 9999 with `tick`=1, the count becomes 0000 and `ovf` is set; counting continues.
- `disp` = lap register in LAP, live count otherwise. This is a combinational mux of registered values.

## Timing
- Reset (async, on `reset_`=0) forces, without waiting for a clock edge:
  - state IDLE;
  - digits 0000;
  - lap register 0000;
  - prescaler 0;
  - outputs `disp`=0000, `running`=0, `lap_on`=0, `ovf`=0.
- Reset asserted mid-count aborts immediately. After deassertion the block stays in IDLE until `ss`.
- Latency from `ss` to the first increment:
  - `ss` is sampled at edge N and the state becomes RUN at N.
  - The first count update happens at edge N+PRESCALE.
  - Later updates occur every PRESCALE edges.
- `running` and `lap_on` are registered state decodes and are valid in the cycle after the sampling edge.
- The count update and `ovf` set happen on the same edge as the 9999→0000 transition.
- A `tick` coinciding with `ss` in RUN is still applied, so the count includes that increment, and the state goes to STOP.
- A `tick` coinciding with `lr` in RUN is also applied. The lap register captures the pre-increment value.
- `ss`/`lr` held high for multiple cycles count as multiple requests; pulse shaping is the upstream's responsibility.

## Structure
- Shared package holds:
  - state encodings `S_IDLE`, `S_RUN`, `S_LAP`, `S_STOP`;
  - BCD constants `BCD_MAX`=4'd9 and `BCD_ZERO`=4'd0.
- Sub-module `bcd_digit` is instantiated 4×:
  - inputs `clock`, `reset_`, `clr` (sync clear), `ei`;
  - outputs `q3_q0` (4 bits) and `eu` (enable-out = `ei` & q==9).
  - It increments mod 10.
- The top level contains the FSM, the prescaler, the lap register and the `disp` mux.

## Test plan
All scenarios use `PRESCALE`=4.
- Reset behaviour: assert `reset_`=0 mid-run → `disp`=0000, `running`=0, `ovf`=0 with no clock edge needed; after release the block idles with no counting for 20 cycles.
- Basic count: `ss` pulse, then 40 cycles → `disp`=0010 and `running`=1; a second `ss` freezes `disp` at the current value for 20 cycles.
- Lap hold: RUN to 0025, pulse `lr` → `disp` stays 0025 while the internal count reaches 0035 (40 cycles); `lr` again → `disp`=0035.
- Clear: STOP at 0042, pulse `lr` → `disp`=0000 and IDLE; `lr` in IDLE has no effect; simultaneous `ss`+`lr` in RUN → STOP with count retained.
- Wrap: force the count to 9998 by running 9998×4 cycles → after 8 more cycles `disp`=0000, `ovf`=1, `running`=1; `ovf` clears only via clear or reset.
- Carry chain: check the transitions 0009→0010, 0099→0100 and 0999→1000 each on a single edge, with no digit ever outside 0..9.
